// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle unsigned MULTU/DIVU with architectural HI/LO.
// Optional MULDIV_FAST_MULT_EN: single-cycle multiply written at the start edge.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_multu,
   input  logic             start_divu,
   input  logic             rd_lo,
   input  logic             rd_hi,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               last;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_rem;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_multu) begin
`ifdef MULDIV_FAST_MULT_EN
               state_d = IDLE;
`else
               state_d = MUL;
`endif
            end else if (start_divu) begin
               state_d = DIV;
            end
         end
         MUL, DIV: if (last) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // acc holds {partial product, multiplier} for MUL and {rem, dividend} for DIV
   always_comb begin
      last     = (cnt_q == CNT_W'(WIDTH - 1));
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_rem - {1'b0, opb_q};
      div_ge   = (div_rem >= {1'b0, opb_q});
      div_next = {div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0],
                  acc_q[WIDTH-2:0], div_ge};
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opb_d  = opb_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_multu) begin
`ifdef MULDIV_FAST_MULT_EN
               {hi_d, lo_d} = (2*WIDTH)'(rs_val) * (2*WIDTH)'(rt_val);
               done_d       = 1'b1;
`else
               acc_d = {{WIDTH{1'b0}}, rt_val};
               opb_d = rs_val;
               cnt_d = '0;
`endif
            end else if (start_divu) begin
               acc_d = {{WIDTH{1'b0}}, rs_val};
               opb_d = rt_val;
               cnt_d = '0;
            end
         end
         MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               {hi_d, lo_d} = mul_next;
               done_d       = 1'b1;
               cnt_d        = '0;
            end
         end
         DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               {hi_d, lo_d} = div_next;
               done_d       = 1'b1;
               cnt_d        = '0;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opb_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opb_q  <= opb_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      busy    = (state_q != IDLE);
      stall   = busy & (rd_lo | rd_hi | start_multu | start_divu);
      rd_data = rd_lo ? lo_q : hi_q;
      hi      = hi_q;
      lo      = lo_q;
      done    = done_q;
   end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed and random MULTU/DIVU sequences checked
// against an arithmetic HI/LO reference model.
module tb_muldiv_hilo_unit;
   localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_multu;
   logic         start_divu;
   logic         rd_lo;
   logic         rd_hi;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic [W-1:0] rd_data;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         stall;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_multu(start_multu), .start_divu(start_divu),
      .rd_lo(rd_lo), .rd_hi(rd_hi),
      .rs_val(rs_val), .rt_val(rt_val),
      .rd_data(rd_data), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // HI/LO as the architecture defines them, from plain arithmetic
   function automatic logic [63:0] ref_res(input bit is_mul,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      if (is_mul) return 64'(a) * 64'(b);
      if (b == '0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic run_op(input bit sm, input bit sd,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold_lo, input bit pulse_div);
      int n;
      int busy_n;
      int stall_bad;
      int exp_n;
      logic [63:0] e;
      e = ref_res(sm, a, b);
      exp_n = (sm && FAST) ? 0 : 32;
      @(negedge clk);
      start_multu = sm;
      start_divu  = sd;
      rs_val      = a;
      rt_val      = b;
      @(negedge clk);
      start_multu = 1'b0;
      start_divu  = 1'b0;
      rs_val      = $urandom;
      rt_val      = $urandom;
      rd_lo       = hold_lo;
      n = 0;
      busy_n = 0;
      stall_bad = 0;
      while (1) begin
         #1;
         if (done === 1'b1 || n >= 100) break;
         if (busy === 1'b1) busy_n++;
         if (stall !== (busy & (hold_lo | start_divu))) stall_bad++;
         if (start_divu) chk("stall_on_ignored_start", 64'(stall), 64'd1);
         @(negedge clk);
         start_divu = pulse_div && (n == 4);
         n++;
      end
      start_divu = 1'b0;
      chk("latency", 64'(n), 64'(exp_n));
      chk("busy_cycles", 64'(busy_n), 64'(exp_n));
      chk("stall_pattern", 64'(stall_bad), 64'd0);
      chk("busy_in_done", 64'(busy), 64'd0);
      chk("stall_in_done", 64'(stall), 64'd0);
      chk("hi", 64'(hi), 64'(e[63:32]));
      chk("lo", 64'(lo), 64'(e[31:0]));
      if (hold_lo) chk("rd_data_lo", 64'(rd_data), 64'(e[31:0]));
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      @(negedge clk);
      rd_lo = 1'b0;
      #1;
      chk("done_width", 64'(done), 64'd0);
      chk("hi_hold", 64'(hi), 64'(exp_hi));
      chk("lo_hold", 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int done_seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit rm;
      rst_n = 1'b0;
      start_multu = 1'b0;
      start_divu = 1'b0;
      rd_lo = 1'b0;
      rd_hi = 1'b0;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      rst_n = 1'b1;

      run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 1'b0);

      rd_lo = 1'b0;
      rd_hi = 1'b1;
      #1;
      chk("rd_data_hi", 64'(rd_data), 64'd0);
      rd_lo = 1'b1;
      #1;
      chk("rd_data_prio", 64'(rd_data), 64'd42);
      rd_lo = 1'b0;
      rd_hi = 1'b0;

      run_op(1'b1, 1'b1, 32'd9, 32'd3, 1'b0, !FAST);
      chk("both_start_lo", 64'(lo), 64'd27);

      @(negedge clk);
      start_multu = 1'b1;
      rs_val = 32'd3;
      rt_val = 32'd4;
      @(negedge clk);
      start_multu = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) done_seen++;
      end
      chk("midrst_no_done", 64'(done_seen), 64'd0);
      run_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         rm = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
         run_op(rm, !rm, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
